gauge_servo_driver: RTL and testbench
=====================================

// Module: gauge_servo_driver
// PURPOSE
//  Dashboard needle stage, downstream of the speed/gear controller. Maps (speed, gear) to a servo
//  pulse width and slews the needle one step per PWM frame toward that target. Emits a 50 Hz
//  servo PWM built from 10 kHz ticks. Runs on the 100 MHz system clock with a tick enable.
// PARAMETERS
//  FRAME_TICKS  200  ticks per PWM frame (200 x 100 us = 20 ms)
//  MIN_W        5    pulse width in ticks at speed 0 (0.5 ms)
//  MAX_W        25   pulse width in ticks at gear full-scale speed (2.5 ms); MAX_W < FRAME_TICKS
//  STEP         1    max width change per frame (ticks); must be >= 1
// PORTS
//  clk_100mhz   in   1  system clock
//  rst_btn      in   1  synchronous, active-high reset
//  tick_10khz   in   1  one-cycle strobe, 10 kHz; all state advances only when high
//  speed        in   4  current speed 0..15
//  gear         in   3  gear select; 1..5 valid
//  servo_pwm    out  1  registered servo pulse
//  gauge_pos    out  8  pulse width (ticks) applied in the current frame
//  settled      out  1  high when gauge_pos == target at last frame boundary
// BEHAVIOUR
//  Full-scale table FS(gear): 1->3, 2->5, 3->7, 4->9, 5->11; gear 0/6/7 -> target = MIN_W.
//  Target: s = min(speed, FS); target = MIN_W + floor(s*(MAX_W-MIN_W)/FS). Combinational,
//   >= 9-bit intermediates. E.g. g1 s3 -> 25; g3 s2 -> 10; g3 s7 -> 25; g5 s1 -> 6.
//  frame_cnt: 0..FRAME_TICKS-1; increments on tick; wraps to 0 after FRAME_TICKS-1.
//  Frame boundary = tick while frame_cnt == FRAME_TICKS-1. Only here: target is sampled, FSM
//   steps, gauge_pos updates, settled updates. Width is therefore constant within a frame.
//  FSM (evaluated at boundary, next state from new gauge_pos vs sampled target):
//   HOLD    : pos == target; stay. -> SLEW_UP if target > pos, SLEW_DN if target < pos.
//   SLEW_UP : pos <= min(pos+STEP, target); -> HOLD when equal.
//   SLEW_DN : pos <= max(pos-STEP, target); -> HOLD when equal.
//   Target reversal mid-slew: direction changes at the next boundary; no overshoot, ever.
//   Speed/gear changes between boundaries are ignored until the next boundary.
//  servo_pwm: on each tick, <= (next frame_cnt < gauge_pos in force for that slot). Exactly
//   gauge_pos high ticks per frame, contiguous, starting at frame slot 0. 1-cycle reg latency.
//  Reset: frame_cnt=0, gauge_pos=MIN_W, state=HOLD, servo_pwm=0, settled=1. Reset mid-frame
//   aborts the frame; the first post-reset frame begins at the first tick after reset releases.
//  Without ticks, all outputs hold. The target is a pure function of the sampled inputs.
// CONFIGURATION
//  GAUGE_SWEEP_EN defined: after reset, a power-on needle sweep runs first. SWEEP_UP slews to
//   MAX_W, then SWEEP_DN slews to MIN_W, then HOLD. Both use STEP per frame. Inputs are ignored
//   and settled=0 during the sweep. Reset-to-tracking is 2*(MAX_W-MIN_W)/STEP frames (40 default).
//  GAUGE_SWEEP_EN undefined: the sweep states do not exist; tracking starts at the first frame.
// TESTING
//  T1 reset, g1 s0, 12000 ticks -> every 200-tick window has 5 high ticks; settled=1.
//  T2 g1 s3 from rest -> gauge_pos 6,7,..,25 on successive boundaries (20 frames). Then 25 high
//     ticks/frame, settled=1.
//  T3 from pos 25, g3 s2 -> target 10; 15 frames down, then 10 high ticks/frame. No width <10 seen.
//  T4 mid-slew reversal: at pos 15 rising to 25, set s0 -> next frame 14, monotonic to 5.
//  T5 gear 0/6/7 with s9 -> target 5. Speed change mid-frame -> current frame width unchanged.
//  T6 GAUGE_SWEEP_EN: reset with g1 s3 -> widths 5..25..5 over 40 frames, settled=0. Then rises
//     to 25. Assert rst_btn mid-frame -> next cycle servo_pwm=0, gauge_pos=5.

Source files
------------

// File: rtl/gauge_servo_driver.sv
// Dashboard needle servo: maps (speed, gear) to a pulse width and slews it one STEP per 20 ms frame.
// Optional power-on sweep via GAUGE_SWEEP_EN; the default build tracks from the first frame.
`timescale 1ns/1ps
module gauge_servo_driver #(
  parameter int FRAME_TICKS = 200,
  parameter int MIN_W       = 5,
  parameter int MAX_W       = 25,
  parameter int STEP        = 1
) (
  input  logic       clk_100mhz,
  input  logic       rst_btn,
  input  logic       tick_10khz,
  input  logic [3:0] speed,
  input  logic [2:0] gear,
  output logic       servo_pwm,
  output logic [7:0] gauge_pos,
  output logic       settled
);
  localparam int              CW     = $clog2(FRAME_TICKS);
  localparam logic [CW-1:0]   LAST   = CW'(FRAME_TICKS - 1);
  localparam logic [7:0]      MIN_P  = 8'(MIN_W);
  localparam logic [7:0]      STEP_P = 8'(STEP);
`ifdef GAUGE_SWEEP_EN
  localparam logic [7:0]      MAX_P  = 8'(MAX_W);
  typedef enum logic [2:0] {S_HOLD, S_SLEW_UP, S_SLEW_DN, S_SWEEP_UP, S_SWEEP_DN} state_t;
`else
  typedef enum logic [2:0] {S_HOLD, S_SLEW_UP, S_SLEW_DN} state_t;
`endif

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [7:0]      r_pos;
  logic            r_pwm;

  logic [3:0]      w_fs, w_s;
  logic [8:0]      w_prod, w_quot;
  logic [7:0]      w_target, w_goal, w_pos_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_bound;
  state_t          w_state_nxt;

  // Full-scale speed per gear; zero marks an invalid gear that parks the needle at MIN_W.
  always_comb begin
    case (gear)
      3'd1:    w_fs = 4'd3;
      3'd2:    w_fs = 4'd5;
      3'd3:    w_fs = 4'd7;
      3'd4:    w_fs = 4'd9;
      3'd5:    w_fs = 4'd11;
      default: w_fs = 4'd0;
    endcase
    w_s      = (speed > w_fs) ? w_fs : speed;
    w_prod   = 9'(w_s) * 9'(MAX_W - MIN_W);
    w_quot   = (w_fs == 4'd0) ? 9'd0 : w_prod / 9'(w_fs);
    w_target = MIN_P + w_quot[7:0];
  end

  always_comb begin
    w_bound = tick_10khz && (r_cnt == LAST);
    w_goal  = w_target;
`ifdef GAUGE_SWEEP_EN
    if (r_state == S_SWEEP_UP)      w_goal = MAX_P;
    else if (r_state == S_SWEEP_DN) w_goal = MIN_P;
`endif
    // Clamp each step to the goal so a reversal or small move never overshoots.
    w_pos_nxt = r_pos;
    if (w_bound) begin
      if (w_goal > r_pos)
        w_pos_nxt = (w_goal - r_pos > STEP_P) ? r_pos + STEP_P : w_goal;
      else if (w_goal < r_pos)
        w_pos_nxt = (r_pos - w_goal > STEP_P) ? r_pos - STEP_P : w_goal;
    end

    w_cnt_nxt = r_cnt;
    if (tick_10khz)
      w_cnt_nxt = (r_cnt == LAST) ? '0 : r_cnt + CW'(1);

    if (w_pos_nxt == w_goal)     w_state_nxt = S_HOLD;
    else if (w_goal > w_pos_nxt) w_state_nxt = S_SLEW_UP;
    else                         w_state_nxt = S_SLEW_DN;
`ifdef GAUGE_SWEEP_EN
    case (r_state)
      S_SWEEP_UP: w_state_nxt = (w_pos_nxt == MAX_P) ? S_SWEEP_DN : S_SWEEP_UP;
      S_SWEEP_DN: begin
        if (w_pos_nxt != MIN_P)         w_state_nxt = S_SWEEP_DN;
        else if (w_target == MIN_P)     w_state_nxt = S_HOLD;
        else                            w_state_nxt = S_SLEW_UP;
      end
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst_btn) begin
      r_cnt   <= '0;
      r_pos   <= MIN_P;
      r_pwm   <= 1'b0;
`ifdef GAUGE_SWEEP_EN
      r_state <= S_SWEEP_UP;
`else
      r_state <= S_HOLD;
`endif
    end else if (tick_10khz) begin
      r_cnt <= w_cnt_nxt;
      // Slot 0 of a new frame already uses the width chosen at the boundary.
      r_pwm <= (32'(w_cnt_nxt) < 32'(w_pos_nxt));
      if (w_bound) begin
        r_pos   <= w_pos_nxt;
        r_state <= w_state_nxt;
      end
    end
  end

  assign servo_pwm = r_pwm;
  assign gauge_pos = r_pos;
  assign settled   = (r_state == S_HOLD);
endmodule

// File: tb/tb_gauge_servo_driver.sv
// Bench for gauge_servo_driver: per-cycle reference model, directed slew sequences, target table, random traffic.
`timescale 1ns/1ps
module tb_gauge_servo_driver;
  localparam int FT = 200, MIN_W = 5, MAX_W = 25, STEP = 1;

  logic       clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic [3:0] speed = 4'd0;
  logic [2:0] gear = 3'd1;
  logic       pwm, set;
  logic [7:0] pos;

  always #5 clk = ~clk;

  gauge_servo_driver dut (
    .clk_100mhz(clk), .rst_btn(rst), .tick_10khz(tick),
    .speed(speed), .gear(gear),
    .servo_pwm(pwm), .gauge_pos(pos), .settled(set)
  );

  int   n_vec = 0, n_err = 0;
  int   m_cnt = 0, m_pos = MIN_W, last_slot0 = 0;
  logic m_pwm = 1'b0, m_set = 1'b1;
  bit   boundary = 0;

  typedef struct { logic [2:0] g; logic [3:0] s; int exp; } vec_t;
  vec_t tbl[13];

  function automatic int ref_target(input int g, input int s);
    int fs;
    fs = (g >= 1 && g <= 5) ? 2 * g + 1 : 0;
    if (fs == 0) return MIN_W;
    if (s > fs) s = fs;
    return MIN_W + (s * (MAX_W - MIN_W)) / fs;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive at negedge, then advance the model and compare just after the edge.
  task automatic step(input logic t, input logic r);
    int tg;
    @(negedge clk);
    tick = t; rst = r;
    @(posedge clk);
    #1;
    boundary = 0;
    if (r) begin
      m_cnt = 0; m_pos = MIN_W; m_pwm = 1'b0; m_set = 1'b1;
    end else if (t) begin
      if (m_cnt == FT - 1) begin
        boundary = 1;
        tg = ref_target(int'(gear), int'(speed));
        if (tg > m_pos)      m_pos = (m_pos + STEP < tg) ? m_pos + STEP : tg;
        else if (tg < m_pos) m_pos = (m_pos - STEP > tg) ? m_pos - STEP : tg;
        m_set = (m_pos == tg);
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_pwm = (m_cnt < m_pos);
    end
    check("cycle {pwm,settled,pos}", {22'd0, pwm, set, pos}, {22'd0, m_pwm, m_set, 8'(m_pos)});
  endtask

  task automatic do_tick();
    if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 2)) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
  endtask

  // Runs to the next frame boundary; hi = high ticks over slots 0..FT-1 of the frame just ended.
  task automatic run_frame(input int chg_at, input logic [2:0] ng, input logic [3:0] ns, output int hi);
    hi = last_slot0;
    for (int i = 0; i < FT + 2; i++) begin
      if (i == chg_at) begin gear = ng; speed = ns; end
      do_tick();
      if (boundary) begin
        last_slot0 = int'(pwm);
        break;
      end
      hi += int'(pwm);
    end
  endtask

  initial begin
    int hi, nf;
    tbl[0]  = '{3'd0, 4'd9,  5};
    tbl[1]  = '{3'd6, 4'd9,  5};
    tbl[2]  = '{3'd7, 4'd9,  5};
    tbl[3]  = '{3'd5, 4'd1,  6};
    tbl[4]  = '{3'd3, 4'd2,  10};
    tbl[5]  = '{3'd2, 4'd3,  17};
    tbl[6]  = '{3'd3, 4'd7,  25};
    tbl[7]  = '{3'd4, 4'd9,  25};
    tbl[8]  = '{3'd5, 4'd15, 25};
    tbl[9]  = '{3'd4, 4'd4,  13};
    tbl[10] = '{3'd2, 4'd1,  9};
    tbl[11] = '{3'd1, 4'd2,  18};
    tbl[12] = '{3'd1, 4'd0,  5};

    repeat (3) step(1'b1, 1'b1);
    check("reset_pwm", pwm, 0);
    check("reset_pos", pos, MIN_W);
    check("reset_settled", set, 1);
    run_frame(-1, 3'd0, 4'd0, hi);

    // Idle needle: MIN_W-wide pulses
    repeat (3) begin
      run_frame(-1, 3'd0, 4'd0, hi);
      check("t1_width", hi, 5);
      check("t1_settled", set, 1);
    end

    // Full-scale climb in gear 1
    gear = 3'd1; speed = 4'd3;
    for (int k = 1; k <= 20; k++) begin
      run_frame(-1, 3'd0, 4'd0, hi);
      check("t2_pos", pos, 5 + k);
    end
    run_frame(-1, 3'd0, 4'd0, hi);
    check("t2_width", hi, 25);
    check("t2_settled", set, 1);

    // Descent to an intermediate target, never below it
    gear = 3'd3; speed = 4'd2;
    for (int k = 1; k <= 15; k++) begin
      run_frame(-1, 3'd0, 4'd0, hi);
      check("t3_pos", pos, 25 - k);
    end
    run_frame(-1, 3'd0, 4'd0, hi);
    check("t3_width", hi, 10);

    // Reversal mid-slew
    gear = 3'd1; speed = 4'd3;
    for (int k = 1; k <= 5; k++) begin
      run_frame(-1, 3'd0, 4'd0, hi);
      check("t4_rise", pos, 10 + k);
    end
    run_frame(73, 3'd1, 4'd0, hi);
    check("t4_reverse", pos, 14);
    for (int k = 1; k <= 9; k++) begin
      run_frame(-1, 3'd0, 4'd0, hi);
      check("t4_fall", pos, 14 - k);
    end
    check("t4_settled", set, 1);

    // Target table
    foreach (tbl[i]) begin
      gear = tbl[i].g; speed = tbl[i].s;
      nf = 0;
      while (pos != 8'(tbl[i].exp) && nf < 30) begin
        run_frame(-1, 3'd0, 4'd0, hi);
        nf++;
      end
      check("tbl_pos", pos, tbl[i].exp);
      check("tbl_settled", set, 1);
      run_frame(-1, 3'd0, 4'd0, hi);
      check("tbl_width", hi, tbl[i].exp);
    end

    // Input change mid-frame leaves the running frame's width alone
    gear = 3'd0; speed = 4'd9;
    run_frame(100, 3'd1, 4'd3, hi);
    check("t5_midframe_width", hi, 5);
    check("t5_next_pos", pos, 6);

    // Random traffic against the model
    repeat (40) begin
      run_frame(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 198)) : -1,
                3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), hi);
    end

    // Reset mid-frame with the pulse high
    gear = 3'd1; speed = 4'd3;
    repeat (3) run_frame(-1, 3'd0, 4'd0, hi);
    repeat (3) step(1'b1, 1'b0);
    check("mid_pwm_before", pwm, 1);
    step(1'b1, 1'b1);
    check("mid_reset_pwm", pwm, 0);
    check("mid_reset_pos", pos, MIN_W);
    check("mid_reset_settled", set, 1);
    last_slot0 = 0;
    run_frame(-1, 3'd0, 4'd0, hi);
    check("post_reset_pos", pos, 6);
    repeat (2) run_frame(-1, 3'd0, 4'd0, hi);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
